// File: rtl/btn_debounce_pulse_pkg.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse_pkg
//   Shared definitions for the pushbutton debounce / press-strobe block:
//   the default debounce window and the 2-bit FSM state encoding.
//   The encoding is chosen so that state bit 1 is the debounced level
//   (HELD, CHK_REL) and state bit 0 is the "checking" flag (CHK_PRESS,
//   CHK_REL). Both outputs can therefore come straight off state flops.
// -----------------------------------------------------------------------------
package btn_debounce_pulse_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;  // stable released
  localparam state_t CHK_PRESS = 2'd1;  // qualifying a press
  localparam state_t HELD      = 2'd2;  // stable pressed
  localparam state_t CHK_REL   = 2'd3;  // qualifying a release

endpackage

// File: rtl/btn_debounce_pulse_sync.sv
// -----------------------------------------------------------------------------
// sync2
//   Two-flop synchronizer for a single asynchronous level. Kept generic so
//   other input stages can reuse it.
//   Ports:
//     CLK    in  destination clock
//     RST_N  in  asynchronous active-low reset (both flops clear to 0)
//     D      in  asynchronous input level
//     Q      out synchronized level (second flop)
// -----------------------------------------------------------------------------
module sync2 (
  input  logic CLK,
  input  logic RST_N,
  input  logic D,
  output logic Q
);

  logic meta_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= 1'b0;
      Q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so the second flop takes the first flop's
      // pre-edge value; blocking here would collapse the chain to one stage.
      meta_q <= D;
      Q      <= meta_q;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// btn_debounce_pulse
//   Debounces a raw pushbutton and emits a one-cycle strobe per accepted
//   press. The raw input is synchronized, then a 4-state FSM requires
//   DEBOUNCE_CYCLES consecutive stable samples before accepting a level
//   change in either direction. Any reversal during a check aborts it.
//   Ports:
//     CLK    in  clock, all state on rising edge
//     RST_N  in  asynchronous active-low reset
//     BTN    in  raw bouncing button level (1 = pressed)
//     PULSE  out registered one-cycle strobe on each accepted press
//     LEVEL  out registered debounced level
//     BUSY   out high while a press or release is being qualified
// -----------------------------------------------------------------------------
module btn_debounce_pulse
  import btn_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT  // legal 2..65535
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic PULSE,
  output logic LEVEL,
  output logic BUSY
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_sync;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  sync2 u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .D     (BTN),
    .Q     (btn_sync)
  );

  // State register: FSM state, stability counter and press strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic. The counter only advances inside a CHK_* state and
  // is zero everywhere else, so every new check starts counting from 0.
  always_comb begin
    // NOTE: every variable gets a default first so no branch can leave it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) state_d = CHK_PRESS;
      end
      CHK_PRESS: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          pulse_d = 1'b1;  // strobe lands on the same edge as HELD
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_sync) state_d = CHK_REL;
      end
      CHK_REL: begin
        if (btn_sync) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pure flop bits, no gating, so nothing from BTN reaches a pin
  // combinationally and reset deassertion cannot glitch them.
  always_comb begin
    PULSE = pulse_q;
    LEVEL = state_q[1];
    BUSY  = state_q[0];
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_pulse
//   Directed bench for btn_debounce_pulse. A DEBOUNCE_CYCLES=4 instance is
//   the main target; a DEBOUNCE_CYCLES=2 instance shares the stimulus and is
//   checked on reset and on the repeated-press sequence.
// -----------------------------------------------------------------------------
module tb_btn_debounce_pulse;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b0;
  logic pulse4, level4, busy4;
  logic pulse2, level2, busy2;

  int n_cmp = 0;
  int n_bad = 0;

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(4)) dut4 (
    .CLK(clk), .RST_N(rst_n), .BTN(btn),
    .PULSE(pulse4), .LEVEL(level4), .BUSY(busy4)
  );

  btn_debounce_pulse #(.DEBOUNCE_CYCLES(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .BTN(btn),
    .PULSE(pulse2), .LEVEL(level2), .BUSY(busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn;
    logic pulse;
    logic level;
    logic busy;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input logic b, input logic p,
                         input logic l, input logic y);
    vecs[i].btn   = b;
    vecs[i].pulse = p;
    vecs[i].level = l;
    vecs[i].busy  = y;
  endtask

  initial begin
    int pulses, wrong_pos, wide;
    int pulses2, wrong_pos2, wide2;
    logic prev4, prev2;
    bit bnc_btn[12]  = '{1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    bit bnc_busy[12] = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};

    // Clean press (edges 1..10) then clean release (edges 11..18), N=4.
    // Press: SYNC high after edge 2, CHK_PRESS edges 3..6, HELD at 7.
    // Release: CHK_REL edges 13..16, IDLE at 17.
    for (int i = 0; i < 10; i++)
      set_vec(i, 1'b1, (i == 6), (i >= 6), (i >= 2 && i <= 5));
    for (int i = 10; i < 18; i++)
      set_vec(i, 1'b0, 1'b0, (i <= 15), (i >= 12 && i <= 15));

    // ---- reset state ----
    btn   = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_pulse4", pulse4, 0);
    check("rst_level4", level4, 0);
    check("rst_busy4",  busy4,  0);
    check("rst_pulse2", pulse2, 0);
    check("rst_level2", level2, 0);
    check("rst_busy2",  busy2,  0);
    rst_n = 1'b1;
    tick();
    tick();
    check("post_rst_busy4", busy4, 0);

    // ---- table: clean press and release ----
    for (int i = 0; i < 18; i++) begin
      btn = vecs[i].btn;
      tick();
      check($sformatf("tbl_pulse_e%0d", i + 1), pulse4, vecs[i].pulse);
      check($sformatf("tbl_level_e%0d", i + 1), level4, vecs[i].level);
      check($sformatf("tbl_busy_e%0d",  i + 1), busy4,  vecs[i].busy);
    end

    // ---- bounce on press: two aborted checks, no acceptance ----
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      btn = bnc_btn[i];
      tick();
      if (pulse4) pulses++;
      check($sformatf("bnc_busy_e%0d", i + 1), busy4, bnc_busy[i]);
      check($sformatf("bnc_level_e%0d", i + 1), level4, 0);
    end
    check("bnc_pulses", pulses, 0);

    // ---- long hold, bounced release, real release ----
    pulses = 0;
    btn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (pulse4) pulses++;
    end
    check("hold_pulses", pulses, 1);
    check("hold_level", level4, 1);
    for (int i = 0; i < 5; i++) begin
      btn = (i >= 2);  // low 2 cycles, then back high
      tick();
      if (pulse4) pulses++;
      check($sformatf("relbnc_level_e%0d", i + 1), level4, 1);
    end
    check("relbnc_busy_end", busy4, 0);
    btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (pulse4) pulses++;
      check($sformatf("rel_level_e%0d", i), level4, (i < 7) ? 1 : 0);
    end
    check("hold_rel_pulses", pulses, 1);

    // ---- reset mid-check, then reset mid-pulse ----
    btn = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("midchk_busy_before", busy4, 1);
    rst_n = 1'b0;
    #1;
    check("midchk_rst_busy",  busy4,  0);
    check("midchk_rst_level", level4, 0);
    check("midchk_rst_pulse", pulse4, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("midchk_pulse_e%0d", i), pulse4, (i == 7) ? 1 : 0);
    end
    rst_n = 1'b0;  // pulse4 is high right now
    #1;
    check("midpulse_rst_pulse", pulse4, 0);
    check("midpulse_rst_level", level4, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check($sformatf("midpulse_pulse_e%0d", i), pulse4, (i == 7) ? 1 : 0);
    end
    btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("midpulse_level_end", level4, 0);

    // ---- three clean presses on both instances ----
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    pulses  = 0; wrong_pos  = 0; wide  = 0; prev4 = 1'b0;
    pulses2 = 0; wrong_pos2 = 0; wide2 = 0; prev2 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 1; k <= 24; k++) begin
        btn = (k <= 12);
        tick();
        if (pulse4) begin
          pulses++;
          if (k != 7) wrong_pos++;
          if (prev4) wide++;
        end
        if (pulse2) begin
          pulses2++;
          if (k != 5) wrong_pos2++;
          if (prev2) wide2++;
        end
        prev4 = pulse4;
        prev2 = pulse2;
      end
    end
    check("rep_pulses_n4",    pulses,     3);
    check("rep_wrongpos_n4",  wrong_pos,  0);
    check("rep_wide_n4",      wide,       0);
    check("rep_pulses_n2",    pulses2,    3);
    check("rep_wrongpos_n2",  wrong_pos2, 0);
    check("rep_wide_n2",      wide2,      0);
    check("rep_level_end_n4", level4,     0);
    check("rep_level_end_n2", level2,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
